rv32_divider: RTL



---
 rtl/rv32_pkg.sv | 18 +
 rtl/div_step.sv | 47 ++++
 rtl/rv32_divider.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, M-extension funct3 encodings
// used by the divider, and the divider state encoding.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] F3_DIV  = 2'b00;
    localparam logic [1:0] F3_DIVU = 2'b01;
    localparam logic [1:0] F3_REM  = 2'b10;
    localparam logic [1:0] F3_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtraction of the divisor from
// the shifted partial remainder, built as a ripple of full-adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module div_step #(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            quo_bit
);

    logic [XLEN:0]   divisor_inv;
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] carry;

    // Subtraction as addition of the inverted, zero-extended divisor plus one.
    assign divisor_inv = ~{1'b0, divisor};
    assign carry[0]    = 1'b1;

    for (genvar i = 0; i <= XLEN; i++) begin : g_cell
        full_adder u_fa (
            .a    (rem_in[i]),
            .b    (divisor_inv[i]),
            .cin  (carry[i]),
            .sum  (trial[i]),
            .cout (carry[i+1])
        );
    end

    // Trial is non-negative when no borrow occurred and its sign bit is clear.
    assign quo_bit = carry[XLEN+1] & ~trial[XLEN];
    assign rem_out = quo_bit ? trial[XLEN-1:0] : rem_in[XLEN-1:0];

endmodule

// File: rtl/rv32_divider.sv
// Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes at start, one quotient bit is produced
// per cycle, and signs are restored in a final fix-up cycle.
module rv32_divider #(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import rv32_pkg::*;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    logic            sel_rem_q;
    logic            quo_neg_q;
    logic            rem_neg_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] divisor_mag_q;
    logic [CW-1:0]   count;

    logic            is_signed;
    logic            sel_rem;
    logic            dividend_neg;
    logic            divisor_neg;
    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] step_rem;
    logic            step_bit;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    // Decode the incoming request: signedness, magnitudes and special cases.
    always_comb begin
        is_signed    = (op == F3_DIV) || (op == F3_REM);
        sel_rem      = (op == F3_REM) || (op == F3_REMU);
        dividend_neg = is_signed & dividend[XLEN-1];
        divisor_neg  = is_signed & divisor[XLEN-1];
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg ? -divisor : divisor;
        div_zero     = (divisor == '0);
        overflow     = is_signed && (dividend == MOST_NEG) && (divisor == '1);
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  ({rem_q, quo_q[XLEN-1]}),
        .divisor (divisor_mag_q),
        .rem_out (step_rem),
        .quo_bit (step_bit)
    );

    // Restore signs: quotient negative on sign mismatch, remainder follows dividend.
    always_comb begin
        quo_fixed = quo_neg_q ? -quo_q : quo_q;
        rem_fixed = rem_neg_q ? -rem_q : rem_q;
    end

    // Control FSM and datapath registers; kill aborts without touching result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= DIV_IDLE;
            sel_rem_q     <= 1'b0;
            quo_neg_q     <= 1'b0;
            rem_neg_q     <= 1'b0;
            rem_q         <= '0;
            quo_q         <= '0;
            divisor_mag_q <= '0;
            count         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
        end else if (kill) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        sel_rem_q <= sel_rem;
                        count     <= '0;
                        busy      <= 1'b1;
                        if (div_zero || overflow) begin
                            quo_neg_q <= 1'b0;
                            rem_neg_q <= 1'b0;
                            quo_q     <= div_zero ? '1 : MOST_NEG;
                            rem_q     <= div_zero ? dividend : '0;
                            state     <= DIV_FIX;
                        end else begin
                            quo_neg_q     <= dividend_neg ^ divisor_neg;
                            rem_neg_q     <= dividend_neg;
                            quo_q         <= dividend_mag;
                            rem_q         <= '0;
                            divisor_mag_q <= divisor_mag;
                            state         <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[XLEN-2:0], step_bit};
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    result <= sel_rem_q ? rem_fixed : quo_fixed;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
